// File: rtl/instr_fetch_if.sv
// Bus between the instruction fetch stage and its surroundings: program load port,
// start strobe, execute-stage handshake and fetch status.
interface instr_fetch_if #(
   parameter int unsigned AW = 4,
   parameter int unsigned W  = 8
);
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [W-1:0]  load_data;
   logic          start;
   logic [7:0]    exec_pc;
   logic          exec_done;
   logic [W-1:0]  instr;
   logic          instr_valid;
   logic          busy;
   logic          hlt;
   logic          fault;
   logic [7:0]    icount;

   // Side that loads the program and runs the execute stage
   modport master (
      output load_en, load_addr, load_data, start, exec_pc, exec_done,
      input  instr, instr_valid, busy, hlt, fault, icount
   );

   // Fetch stage side
   modport slave (
      input  load_en, load_addr, load_data, start, exec_pc, exec_done,
      output instr, instr_valid, busy, hlt, fault, icount
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: small program memory, one instruction in flight,
// halt-opcode and out-of-range-PC detection, saturating retired-instruction count.
module instr_fetch #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned W     = 8
) (
   input logic         clk,
   input logic         rst_n,
   instr_fetch_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

   localparam logic [7:0] DepthPc = 8'(DEPTH);
   localparam logic [3:0] HaltOp  = 4'hF;

   state_e        state_q, state_d;
   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic [W-1:0]  instr_q, instr_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          hlt_q, hlt_d;
   logic          fault_q, fault_d;
   logic [7:0]    icount_q, icount_d;
   logic          mem_we;

   logic [W-1:0]  mem [DEPTH];

   // Loading is only allowed while no program is running
   assign mem_we = bus.load_en && ((state_q == StIdle) || (state_q == StHalt));

   // Program memory write port; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[bus.load_addr] <= bus.load_data;
      end
   end

   // Next-state and output-register logic
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      hlt_d      = hlt_q;
      fault_d    = fault_q;
      icount_d   = icount_q;
      unique case (state_q)
         StIdle, StHalt: begin
            if (bus.start) begin
               state_d    = StFetch;
               fetch_pc_d = '0;
               hlt_d      = 1'b0;
               fault_d    = 1'b0;
               icount_d   = '0;
            end
         end
         StFetch: begin
            // A write in the same cycle as start landed one edge earlier, so this read sees it
            instr_d = mem[fetch_pc_q];
            valid_d = 1'b1;
            state_d = StIssue;
         end
         StIssue: begin
            if (bus.exec_done) begin
               valid_d = 1'b0;
               if (icount_q != 8'hFF) begin
                  icount_d = icount_q + 8'd1;
               end
               if (instr_q[W-1 -: 4] == HaltOp) begin
                  state_d = StHalt;
                  hlt_d   = 1'b1;
               end else if (bus.exec_pc >= DepthPc) begin
                  state_d = StHalt;
                  hlt_d   = 1'b1;
                  fault_d = 1'b1;
               end else begin
                  fetch_pc_d = bus.exec_pc[AW-1:0];
                  state_d    = StFetch;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d == StFetch) || (state_d == StIssue);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         fetch_pc_q <= '0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         hlt_q      <= 1'b0;
         fault_q    <= 1'b0;
         icount_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         hlt_q      <= hlt_d;
         fault_q    <= fault_d;
         icount_q   <= icount_d;
      end
   end

   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.busy        = busy_q;
   assign bus.hlt         = hlt_q;
   assign bus.fault       = fault_q;
   assign bus.icount      = icount_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   instr_fetch_if #(.AW(4), .W(8)) bus ();

   instr_fetch #(.DEPTH(16), .AW(4), .W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [3:0] addr, input logic [7:0] data);
      bus.load_en   = 1'b1;
      bus.load_addr = addr;
      bus.load_data = data;
      tick();
      bus.load_en   = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic ack(input logic [7:0] pc);
      bus.exec_done = 1'b1;
      bus.exec_pc   = pc;
      tick();
      bus.exec_done = 1'b0;
   endtask

   // Bounded wait for instr_valid; caller checks the result
   task automatic wait_valid();
      for (int i = 0; i < 8 && bus.instr_valid !== 1'b1; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if ({bus.instr, bus.instr_valid, bus.busy, bus.hlt, bus.fault, bus.icount} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got instr=%h v=%b busy=%b hlt=%b fault=%b icount=%0d, need all 0",
                  bus.instr, bus.instr_valid, bus.busy, bus.hlt, bus.fault, bus.icount);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_sequence();
      load_word(4'd0, 8'h91);
      load_word(4'd1, 8'h12);
      load_word(4'd2, 8'hF0);
      pulse_start();
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL seq_busy: got %b need 1", bus.busy);
      end
      wait_valid();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 8'h91) begin
         n_fail++; $display("FAIL seq_instr0: got v=%b %h need v=1 91", bus.instr_valid, bus.instr);
      end
      ack(8'd1);
      n_checks++;
      if (bus.instr_valid !== 1'b0 || bus.icount !== 8'd1 || bus.hlt !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_ack0: got v=%b icount=%0d hlt=%b need v=0 icount=1 hlt=0",
                  bus.instr_valid, bus.icount, bus.hlt);
      end
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 8'h12) begin
         n_fail++; $display("FAIL seq_instr1: got v=%b %h need v=1 12", bus.instr_valid, bus.instr);
      end
      ack(8'd2);
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 8'hF0) begin
         n_fail++; $display("FAIL seq_instr2: got v=%b %h need v=1 f0", bus.instr_valid, bus.instr);
      end
      ack(8'd3);
      n_checks++;
      if (bus.hlt !== 1'b1 || bus.fault !== 1'b0 || bus.icount !== 8'd3 || bus.busy !== 1'b0
          || bus.instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_halt: got hlt=%b fault=%b icount=%0d busy=%b v=%b need 1 0 3 0 0",
                  bus.hlt, bus.fault, bus.icount, bus.busy, bus.instr_valid);
      end
   endtask

   task automatic test_branch();
      load_word(4'd0, 8'hB5);
      load_word(4'd5, 8'hF0);
      pulse_start();
      wait_valid();
      n_checks++;
      if (bus.instr !== 8'hB5) begin
         n_fail++; $display("FAIL br_first: got %h need b5", bus.instr);
      end
      ack(8'd5);
      n_checks++;
      if (bus.instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL br_bubble: got v=%b need 0", bus.instr_valid);
      end
      tick();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 8'hF0) begin
         n_fail++; $display("FAIL br_target: got v=%b %h need v=1 f0", bus.instr_valid, bus.instr);
      end
      ack(8'd6);
   endtask

   task automatic test_fault();
      pulse_start();
      n_checks++;
      if (bus.hlt !== 1'b0 || bus.icount !== 8'd0) begin
         n_fail++; $display("FAIL flt_restart: got hlt=%b icount=%0d need 0 0", bus.hlt, bus.icount);
      end
      wait_valid();
      ack(8'h20);
      n_checks++;
      if (bus.hlt !== 1'b1 || bus.fault !== 1'b1 || bus.instr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flt_halt: got hlt=%b fault=%b v=%b need 1 1 0",
                  bus.hlt, bus.fault, bus.instr_valid);
      end
      // exec_done while halted must not count
      ack(8'd1);
      n_checks++;
      if (bus.icount !== 8'd1) begin
         n_fail++; $display("FAIL flt_done_in_halt: got icount=%0d need 1", bus.icount);
      end
      pulse_start();
      n_checks++;
      if (bus.hlt !== 1'b0 || bus.fault !== 1'b0) begin
         n_fail++; $display("FAIL flt_clear: got hlt=%b fault=%b need 0 0", bus.hlt, bus.fault);
      end
      wait_valid();
      n_checks++;
      if (bus.instr !== 8'hB5) begin
         n_fail++; $display("FAIL flt_refetch: got %h need b5", bus.instr);
      end
   endtask

   task automatic test_load_ignored();
      // Currently in ISSUE holding 0xB5
      load_word(4'd0, 8'h77);
      ack(8'h20);
      pulse_start();
      wait_valid();
      n_checks++;
      if (bus.instr !== 8'hB5) begin
         n_fail++; $display("FAIL ld_ignored: got %h need b5", bus.instr);
      end
      ack(8'h20);
      bus.load_en   = 1'b1;
      bus.load_addr = 4'd0;
      bus.load_data = 8'h77;
      bus.start     = 1'b1;
      tick();
      bus.load_en   = 1'b0;
      bus.start     = 1'b0;
      wait_valid();
      n_checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 8'h77) begin
         n_fail++; $display("FAIL ld_with_start: got v=%b %h need v=1 77", bus.instr_valid, bus.instr);
      end
   endtask

   task automatic test_reset_mid();
      ack(8'd0);
      tick();
      n_checks++;
      if (bus.icount !== 8'd1 || bus.instr_valid !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre: got icount=%0d v=%b need 1 1", bus.icount, bus.instr_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.instr_valid !== 1'b0 || bus.icount !== 8'd0 || bus.busy !== 1'b0
          || bus.instr !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_async: got v=%b icount=%0d busy=%b instr=%h need 0 0 0 00",
                  bus.instr_valid, bus.icount, bus.busy, bus.instr);
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_idle: got busy=%b v=%b need 0 0", bus.busy, bus.instr_valid);
      end
      pulse_start();
      wait_valid();
      n_checks++;
      if (bus.instr !== 8'h77) begin
         n_fail++; $display("FAIL rst_mem_kept: got %h need 77", bus.instr);
      end
   endtask

   task automatic test_saturation();
      ack(8'h20);
      load_word(4'd0, 8'h10);
      pulse_start();
      wait_valid();
      ack(8'd0);
      // Now in FETCH: exec_done here is ignored
      bus.exec_done = 1'b1;
      tick();
      bus.exec_done = 1'b0;
      n_checks++;
      if (bus.icount !== 8'd1 || bus.instr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_done_in_fetch: got icount=%0d v=%b need 1 1", bus.icount, bus.instr_valid);
      end
      for (int i = 1; i < 300; i++) begin
         wait_valid();
         ack(8'd0);
         if (i == 253) begin
            n_checks++;
            if (bus.icount !== 8'd254) begin
               n_fail++; $display("FAIL sat_254: got %0d need 254", bus.icount);
            end
         end
      end
      n_checks++;
      if (bus.icount !== 8'd255 || bus.hlt !== 1'b0) begin
         n_fail++; $display("FAIL sat_255: got icount=%0d hlt=%b need 255 0", bus.icount, bus.hlt);
      end
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.load_en   = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      bus.start     = 1'b0;
      bus.exec_pc   = '0;
      bus.exec_done = 1'b0;
      test_reset();
      test_sequence();
      test_branch();
      test_fault();
      test_load_ignored();
      test_reset_mid();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
